imem_boot_loader: RTL and testbench

Boot sequencer for the riscv_cpu core. It holds the core in reset and streams a program image, word by word, into instruction memory at consecutive word addresses. It then releases the core's reset after a programmable hold interval. It sits between the testbench or host program source and both the instruction-memory write port and the core's `reset_n` input. A new `start` re-enters the load sequence at any time.

---
 rtl/imem_boot_loader_if.sv | 26 ++
 rtl/imem_boot_loader.sv | 74 +++++++
 tb/tb_imem_boot_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: host/source handshake and instruction-memory write bus of the boot loader
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_reset_n;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (
    output start, num_words, s_valid, s_data,
    input  s_ready, mem_we, mem_waddr, mem_wdata, cpu_reset_n, busy, done, err
  );
  modport slave (
    input  start, num_words, s_valid, s_data,
    output s_ready, mem_we, mem_waddr, mem_wdata, cpu_reset_n, busy, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into instruction memory, then releases the core reset
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 4
) (
  input logic               clk,
  input logic               reset_n,
  imem_boot_loader_if.slave bus
);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  state_t                r_state, w_next;
  logic                  w_start_ok, w_xfer, w_last;
  logic [ADDR_WIDTH:0]   r_cnt, r_num;
  logic [ADDR_WIDTH-1:0] r_addr, r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [HW-1:0]         r_hold;
  logic                  r_ready, r_we, r_cpu_rst_n, r_busy, r_done, r_err;
  assign bus.s_ready     = r_ready;
  assign bus.mem_we      = r_we;
  assign bus.mem_waddr   = r_waddr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.cpu_reset_n = r_cpu_rst_n;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  // next state: an accepted start overrides everything, and a word arriving with it is dropped
  always_comb begin
    w_start_ok = bus.start && (bus.num_words <= DEPTH);
    w_xfer     = (r_state == LOAD) && bus.s_valid && !w_start_ok;
    w_last     = w_xfer && (r_cnt + (ADDR_WIDTH + 1)'(1) == r_num);
    w_next     = w_start_ok ? ((bus.num_words == '0) ? HOLD : LOAD) :
                 w_last ? HOLD :
                 (r_state == HOLD && r_hold == HOLD_LAST) ? RUN : r_state;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // counters and flop-driven outputs, all derived from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_num       <= '0;
      r_addr      <= '0;
      r_hold      <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_ready     <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cnt       <= w_start_ok ? '0 : w_xfer ? r_cnt + (ADDR_WIDTH + 1)'(1) : r_cnt;
      r_num       <= w_start_ok ? bus.num_words : r_num;
      r_addr      <= w_start_ok ? '0 : w_xfer ? r_addr + 1'b1 : r_addr;
      r_hold      <= (r_state == HOLD && !w_start_ok) ? r_hold + 1'b1 : '0;
      r_waddr     <= w_xfer ? r_addr : r_waddr;
      r_wdata     <= w_xfer ? bus.s_data : r_wdata;
      r_we        <= w_xfer;
      r_ready     <= w_next == LOAD;
      r_cpu_rst_n <= w_next == RUN;
      r_busy      <= w_next == LOAD || w_next == HOLD;
      r_done      <= w_next == RUN;
      r_err       <= w_start_ok ? 1'b0 : bus.start ? 1'b1 : r_err;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for the boot loader (expected writes queued, monitor compares)
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  logic [39:0] exp_q[$];
  logic [31:0] img[$];

  imem_boot_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  imem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write the DUT presents must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n && bus.mem_we) begin
      logic [39:0] e;
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.mem_waddr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_waddr, bus.mem_wdata} !== e || !bus.busy) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h busy %0b expected addr %0h data %0h busy 1",
                   bus.mem_waddr, bus.mem_wdata, bus.busy, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_start(input int n);
    bus.start = 1'b1;
    bus.num_words = n[8:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle);
    for (int i = 0; i < n; i++) exp_q.push_back({i[7:0], img[i]});
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.s_valid = 1'b1;
      bus.s_data = img[i];
      @(negedge clk);
      while (!bus.s_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk("ready_timeout", 64'(bus.s_ready), 64'd1);
      @(posedge clk); #1;
      if (toggle && i < n - 1) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_release(input string name, input int exp_k);
    int k = 0;
    @(negedge clk);
    while (!bus.cpu_reset_n && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk(name, 64'(k), 64'(exp_k));
    chk({name, "_done"}, 64'(bus.done), 64'd1);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic all_zero(input string name);
    chk(name, 64'({bus.s_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata,
                   bus.cpu_reset_n, bus.busy, bus.done, bus.err}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    #1;
    all_zero("reset_outputs");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    img = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
    w0 = n_writes;
    do_start(4);
    chk("load_busy", 64'(bus.busy), 64'd1);
    chk("load_ready", 64'(bus.s_ready), 64'd1);
    chk("load_cpu_rst", 64'(bus.cpu_reset_n), 64'd0);
    stream(4, 1'b0);
    chk("hold_ready_low", 64'(bus.s_ready), 64'd0);
    wait_release("release_4", 4);
    chk("count_4", 64'(n_writes - w0), 64'd4);

    img = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};
    w0 = n_writes;
    do_start(4);
    chk("restart_cpu_rst", 64'(bus.cpu_reset_n), 64'd0);
    stream(4, 1'b1);
    wait_release("release_toggle", 4);
    chk("count_toggle", 64'(n_writes - w0), 64'd4);

    w0 = n_writes;
    do_start(0);
    chk("zero_busy", 64'(bus.busy), 64'd1);
    chk("zero_ready", 64'(bus.s_ready), 64'd0);
    wait_release("release_zero", 4);
    chk("count_zero", 64'(n_writes - w0), 64'd0);

    w0 = n_writes;
    do_start(257);
    chk("err_set", 64'(bus.err), 64'd1);
    chk("err_state_run", 64'({bus.done, bus.cpu_reset_n, bus.busy}), 64'b110);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'(bus.err), 64'd1);
    chk("err_no_write", 64'(n_writes - w0), 64'd0);

    img = '{32'hCAFE0000, 32'hCAFE0001};
    do_start(2);
    chk("err_clear", 64'(bus.err), 64'd0);
    chk("run_restart", 64'({bus.cpu_reset_n, bus.done, bus.busy, bus.s_ready}), 64'b0011);
    stream(2, 1'b0);
    wait_release("release_2", 4);
    chk("count_2", 64'(n_writes - w0), 64'd2);

    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(32'h5A000000 | i);
    w0 = n_writes;
    do_start(256);
    stream(256, 1'b0);
    wait_release("release_256", 4);
    chk("count_256", 64'(n_writes - w0), 64'd256);

    img = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    do_start(5);
    stream(2, 1'b0);
    bus.s_valid = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    all_zero("midload_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    img = '{32'h77000000, 32'h77000001, 32'h77000002};
    w0 = n_writes;
    do_start(3);
    stream(3, 1'b0);
    wait_release("release_after_reset", 4);
    chk("count_after_reset", 64'(n_writes - w0), 64'd3);

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
